// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: pcsource encoding, bubble word,
// and the fetch FSM state type.
package pipe_pkg;
  // pcsource encoding driven by the ID-stage control unit
  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  // Bubble placed in IF/ID (sll $0,$0,0)
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // RUN:   normal fetch
  // REDIR: taken transfer parked while the delay-slot fetch waits on memory
  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/pipe_fetch_if.sv
// Signal bundle between the fetch stage, the ID stage and instruction memory.
//   pcsource/wpcir/bpc/da/jpc : control and targets from ID
//   imem_rdata/imem_ready     : instruction memory response for pc
//   pc                        : fetch address to instruction memory
//   dpc4/dinst                : IF/ID register contents
// master = fetch stage, slave = ID stage + instruction memory.
interface pipe_fetch_if;
  logic [1:0]  pcsource;
  logic        wpcir;
  logic [31:0] bpc;
  logic [31:0] da;
  logic [31:0] jpc;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] dpc4;
  logic [31:0] dinst;

  modport master (
    input  pcsource, wpcir, bpc, da, jpc, imem_rdata, imem_ready,
    output pc, dpc4, dinst
  );

  modport slave (
    output pcsource, wpcir, bpc, da, jpc, imem_rdata, imem_ready,
    input  pc, dpc4, dinst
  );
endinterface

// File: rtl/pipe_npc_mux.sv
// Combinational next-PC select with the pc+4 adder.
//   i_pc       : current fetch address
//   i_pcsource : select (pc+4 / bpc / da / jpc)
//   i_bpc/i_da/i_jpc : candidate targets
//   o_pc4      : pc+4 (modulo 2^32)
//   o_npc      : selected next PC
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_da,
  input  logic [31:0] i_jpc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_npc
);
  assign o_pc4 = i_pc + 32'd4;

  always_comb begin
    o_npc = o_pc4;
    case (i_pcsource)
      PCS_PC4: o_npc = o_pc4;
      PCS_BR:  o_npc = i_bpc;
      PCS_JR:  o_npc = i_da;
      PCS_J:   o_npc = i_jpc;
    endcase
  end
endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, selects the next PC from ID's pcsource, and absorbs
// instruction-memory wait states without losing a pending transfer.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipe_fetch_if.master (ID control/targets, imem, pc, IF/ID)
// Parameter RESET_PC: pc after reset.
// Build option PIPE_FETCH_FLUSH_EN: when defined, taken transfers have no
// delay slot (IF/ID is bubbled, pc jumps at once) and the REDIR state and
// redir register are not built.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  pipe_fetch_if.master bus
);
  logic [31:0] r_pc;
  logic [31:0] r_dpc4;
  logic [31:0] r_dinst;
  logic [31:0] w_pc4;
  logic [31:0] w_npc;
  logic        w_taken;

  pipe_npc_mux u_npc (
    .i_pc       (r_pc),
    .i_pcsource (bus.pcsource),
    .i_bpc      (bus.bpc),
    .i_da       (bus.da),
    .i_jpc      (bus.jpc),
    .o_pc4      (w_pc4),
    .o_npc      (w_npc)
  );

  assign w_taken = bus.wpcir && (bus.pcsource != PCS_PC4);

`ifdef PIPE_FETCH_FLUSH_EN
  // No delay slot: a taken transfer kills whatever was being fetched.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_dpc4  <= 32'h0;
      r_dinst <= INST_NOP;
    end else if (bus.wpcir) begin
      if (w_taken) begin
        r_dinst <= INST_NOP;
        r_dpc4  <= 32'h0;
        r_pc    <= w_npc;
      end else if (bus.imem_ready) begin
        r_dinst <= bus.imem_rdata;
        r_dpc4  <= w_pc4;
        r_pc    <= w_pc4;
      end else begin
        r_dinst <= INST_NOP;
        r_dpc4  <= 32'h0;
      end
    end
  end
`else
  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_redir;

  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Park in REDIR only when a transfer is taken while the delay-slot word
  // has not yet arrived; leave as soon as that word is captured.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.wpcir) begin
      case (r_state)
        RUN:   if (!bus.imem_ready && w_taken) w_state_nxt = REDIR;
        REDIR: if (bus.imem_ready)             w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_dpc4  <= 32'h0;
      r_dinst <= INST_NOP;
      r_redir <= 32'h0;
    end else if (bus.wpcir) begin
      case (r_state)
        RUN: begin
          if (bus.imem_ready) begin
            r_dinst <= bus.imem_rdata;
            r_dpc4  <= w_pc4;
            r_pc    <= w_npc;
          end else begin
            r_dinst <= INST_NOP;
            r_dpc4  <= 32'h0;
            if (w_taken) r_redir <= w_npc;
          end
        end
        REDIR: begin
          // pcsource is ignored here: ID is holding a bubble.
          if (bus.imem_ready) begin
            r_dinst <= bus.imem_rdata;
            r_dpc4  <= w_pc4;
            r_pc    <= r_redir;
          end else begin
            r_dinst <= INST_NOP;
          end
        end
      endcase
    end
  end
`endif

  assign bus.pc    = r_pc;
  assign bus.dpc4  = r_dpc4;
  assign bus.dinst = r_dinst;
endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined MIPS CPU. It is the consumer of the ID-stage control unit's `pcsource` and `wpcir` outputs. It holds the PC, selects the next PC, and presents fetched instructions to ID. It also absorbs instruction-memory wait states without losing a pending control transfer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pcsource` in 2: next-PC select from ID.
  - 00: pc+4
  - 01: branch target `bpc`
  - 10: register target `da` (jr)
  - 11: jump target `jpc`
- `wpcir` in 1: 0 means ID is stalled (load-use); PC and IF/ID must hold.
- `bpc` in 32: branch target from ID.
- `da` in 32: jr target (rs value) from ID.
- `jpc` in 32: j/jal target from ID.
- `imem_rdata` in 32: instruction word at `pc`; combinational, valid when `imem_ready`=1.
- `imem_ready` in 1: instruction memory has the word at `pc` this cycle.
- `pc` out 32: current fetch address; drives the instruction memory.
- `dpc4` out 32: pc+4 of the instruction in IF/ID.
- `dinst` out 32: instruction in IF/ID; bubble value is 32'h0000_0000 (NOP).

## Operation
- A "taken" transfer means `wpcir`=1 and `pcsource`≠00. The target is selected from `bpc`, `da` or `jpc` per `pcsource`.
- FSM states:
  - RUN: normal fetch.
  - REDIR: a taken transfer is pending while the delay-slot fetch waits on memory.
- `redir` is a 32-bit register holding the pending target.
- The rules below are listed in priority order.
- `wpcir`=0, in any state: `pc`, `dpc4`, `dinst`, state and `redir` all hold. `pcsource` and `imem_ready` are ignored.
- RUN, `imem_ready`=1:
  - `dinst`←`imem_rdata` and `dpc4`←pc+4.
  - `pc`←target if taken, else pc+4.
- RUN, `imem_ready`=0, not taken: `dinst`←NOP, `dpc4`←0, `pc` holds.
- RUN, `imem_ready`=0, taken: `dinst`←NOP, `dpc4`←0, `redir`←target, `pc` holds, go to REDIR. This preserves the delay slot.
- REDIR: `pcsource` is ignored, because ID holds a NOP.
  - `imem_ready`=0: `dinst`←NOP and hold.
  - `imem_ready`=1: `dinst`←`imem_rdata`, `dpc4`←pc+4, `pc`←`redir`, go to RUN.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 = 0. Targets are used unmodified; there is no alignment check.

## Timing
- Reset values:
  - `pc`=`RESET_PC`
  - `dinst`=0
  - `dpc4`=0
  - state=RUN
  - `redir`=0
- Reset takes priority over `wpcir` and every other input.
- Reset asserted while in REDIR discards the pending target.
- Latency: the word at `pc` appears on `dinst` one cycle after the edge where `imem_ready`=1.
- Next-PC selection is combinational from `pcsource` and the target inputs in the same cycle. The new `pc` is visible after the edge.
- Taken branch with delay slot: the delay-slot instruction reaches ID one cycle after the branch leaves ID; the target follows on the next cycle.
- `wpcir`=0 together with `imem_ready`=0: hold wins. IF/ID is not bubbled, because the stalled ID instruction must be re-decoded.

## Configuration
- `PIPE_FETCH_FLUSH_EN`
- Undefined (default): MIPS delay-slot semantics, as described above.
- Defined: no delay slot.
  - A taken transfer loads `dinst`←NOP and `dpc4`←0, regardless of `imem_ready`.
  - `pc`←target immediately, and the outstanding fetch is abandoned.
  - REDIR is never entered; the state register and `redir` are not built.

## Structure
- Shared package `pipe_pkg`:
  - `pcsource` encoding constants: `PCS_PC4`, `PCS_BR`, `PCS_JR`, `PCS_J`.
  - `INST_NOP`.
  - fetch-FSM state typedef (RUN, REDIR).
- One sub-module, `pipe_npc_mux`: the combinational four-way next-PC select, including the pc+4 adder.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100, then 3 cycles with `imem_ready`=1 and `pcsource`=00.
  - `pc` goes 0x100→0x104→0x108→0x10C.
  - `dinst` tracks the memory words one cycle late.
  - `dpc4` is 0x104, 0x108, 0x10C.
- `wpcir`=0 for 2 cycles mid-stream, with `pcsource`=11 and `imem_ready`=0 driven.
  - `pc`, `dinst` and `dpc4` are unchanged for both cycles.
  - Fetch resumes exactly where it stopped.
- Taken beq (`pcsource`=01, `bpc`=0x200) at pc=0x10C with `imem_ready`=1.
  - Default build: the 0x10C word enters ID and `pc`=0x200.
  - Flush build: `dinst`=0 and `pc`=0x200.
- jr (`pcsource`=10, `da`=0x400) while `imem_ready`=0 for 2 cycles, default build.
  - State is REDIR and `dinst`=NOP for 2 cycles.
  - The delay-slot word is then captured and `pc`=0x400.
- `pc`=32'hFFFF_FFFC with `pcsource`=00 and `imem_ready`=1.
  - `pc`=0 and `dpc4`=0.
- Assert `reset` while in REDIR with `redir`=0x400.
  - `pc`=`RESET_PC`, state is RUN, and the first fetch after reset is not redirected.
